// File: rtl/pwm_meter_pkg.sv
// Shared types and default constants for the PWM pulse/period meter.
package pwm_meter_pkg;

   // Measurement phase: IDLE waits for the first fall, LOW counts the low
   // pulse, HIGH counts the remainder of the period.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOW  = 2'd1,
      HIGH = 2'd2
   } meter_state_t;

   // Defaults match the 500-cycle generator (low for 70 cycles).
   localparam int DEF_CNT_W      = 12;
   localparam int DEF_EXP_LOW    = 70;
   localparam int DEF_EXP_PERIOD = 500;

endpackage

// File: rtl/edge_sync.sv
// Two-flop synchronizer followed by a rise/fall detector on the synced level.
// All flops reset to 1 so that leaving reset never looks like a falling edge.
module edge_sync (
   input  logic clock,
   input  logic reset,
   input  logic d,
   output logic level,
   output logic rise,
   output logic fall
);

   logic r_s1;
   logic r_s2;
   logic r_prev;

   // Synchronizer stages plus the one-cycle delayed copy used for edge detection.
   always_ff @(posedge clock) begin
      if (!reset) begin
         r_s1   <= 1'b1;
         r_s2   <= 1'b1;
         r_prev <= 1'b1;
      end else begin
         r_s1   <= d;
         r_s2   <= r_s1;
         r_prev <= r_s2;
      end
   end

   assign level = r_s2;
   assign rise  = ~r_prev &  r_s2;
   assign fall  =  r_prev & ~r_s2;

endmodule

// File: rtl/pwm_pulse_meter.sv
// Measures low-pulse width and fall-to-fall period of f_in in clock cycles.
// One registered result per complete period, flagged by a one-cycle valid
// strobe; a saturated counter aborts the period with a one-cycle timeout.
module pwm_pulse_meter
   import pwm_meter_pkg::*;
#(
   parameter int CNT_W      = DEF_CNT_W,
   parameter int EXP_LOW    = DEF_EXP_LOW,
   parameter int EXP_PERIOD = DEF_EXP_PERIOD
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             en,
   input  logic             f_in,
   output logic [CNT_W-1:0] low_width,
   output logic [CNT_W-1:0] period,
   output logic             valid,
   output logic             match,
   output logic             timeout
);

   localparam logic [CNT_W-1:0] CNT_MAX      = '1;
   localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
   localparam logic [CNT_W-1:0] EXP_LOW_C    = CNT_W'(EXP_LOW);
   localparam logic [CNT_W-1:0] EXP_PERIOD_C = CNT_W'(EXP_PERIOD);

   logic w_level;
   logic w_rise;
   logic w_fall;

   meter_state_t     r_state,     w_next_state;
   logic [CNT_W-1:0] r_cnt,       w_next_cnt;
   logic [CNT_W-1:0] r_low_cap,   w_next_low_cap;
   logic [CNT_W-1:0] r_low_width, w_next_low_width;
   logic [CNT_W-1:0] r_period,    w_next_period;
   logic             r_match,     w_next_match;
   logic             r_valid,     w_next_valid;
   logic             r_timeout,   w_next_timeout;

   edge_sync u_edge_sync (
      .clock (clock),
      .reset (reset),
      .d     (f_in),
      .level (w_level),
      .rise  (w_rise),
      .fall  (w_fall)
   );

   // State, counter and result registers.
   always_ff @(posedge clock) begin
      if (!reset) begin
         r_state     <= IDLE;
         r_cnt       <= '0;
         r_low_cap   <= '0;
         r_low_width <= '0;
         r_period    <= '0;
         r_match     <= 1'b0;
         r_valid     <= 1'b0;
         r_timeout   <= 1'b0;
      end else begin
         r_state     <= w_next_state;
         r_cnt       <= w_next_cnt;
         r_low_cap   <= w_next_low_cap;
         r_low_width <= w_next_low_width;
         r_period    <= w_next_period;
         r_match     <= w_next_match;
         r_valid     <= w_next_valid;
         r_timeout   <= w_next_timeout;
      end
   end

   // Next-state, counter and result logic. Saturation outranks any edge seen
   // in the same cycle; dropping en abandons the current period.
   always_comb begin
      w_next_state     = r_state;
      w_next_cnt       = r_cnt;
      w_next_low_cap   = r_low_cap;
      w_next_low_width = r_low_width;
      w_next_period    = r_period;
      w_next_match     = r_match;
      w_next_valid     = 1'b0;
      w_next_timeout   = 1'b0;
      if (!en) begin
         w_next_state = IDLE;
         w_next_cnt   = '0;
      end else begin
         case (r_state)
            IDLE: begin
               w_next_cnt = '0;
               // A fall always leaves the synced level low; checked explicitly.
               if (w_fall && !w_level) begin
                  w_next_cnt   = CNT_ONE;
                  w_next_state = LOW;
               end
            end
            LOW: begin
               if (r_cnt == CNT_MAX) begin
                  w_next_timeout = 1'b1;
                  w_next_cnt     = '0;
                  w_next_state   = IDLE;
               end else begin
                  w_next_cnt = r_cnt + CNT_ONE;
                  if (w_rise) begin
                     w_next_low_cap = r_cnt;
                     w_next_state   = HIGH;
                  end
               end
            end
            HIGH: begin
               if (r_cnt == CNT_MAX) begin
                  w_next_timeout = 1'b1;
                  w_next_cnt     = '0;
                  w_next_state   = IDLE;
               end else if (w_fall) begin
                  w_next_period    = r_cnt;
                  w_next_low_width = r_low_cap;
                  w_next_match     = (r_low_cap == EXP_LOW_C) && (r_cnt == EXP_PERIOD_C);
                  w_next_valid     = 1'b1;
                  w_next_cnt       = CNT_ONE;
                  w_next_state     = LOW;
               end else begin
                  w_next_cnt = r_cnt + CNT_ONE;
               end
            end
            default: begin
               w_next_state = IDLE;
               w_next_cnt   = '0;
            end
         endcase
      end
   end

   assign low_width = r_low_width;
   assign period    = r_period;
   assign valid     = r_valid;
   assign match     = r_match;
   assign timeout   = r_timeout;

endmodule

// File: tb/tb_pwm_pulse_meter.sv
// Bench for pwm_pulse_meter: directed and random waveforms checked every
// cycle against a timestamp-based model of the measurement rules.
module tb_pwm_pulse_meter;
   import pwm_meter_pkg::*;

   localparam int CNT_W      = 12;
   localparam int MAXC       = 4095;
   localparam int EXP_LOW    = 70;
   localparam int EXP_PERIOD = 500;

   logic             clock = 1'b0;
   logic             reset = 1'b0;
   logic             en    = 1'b0;
   logic             f_in  = 1'b1;
   logic [CNT_W-1:0] low_width;
   logic [CNT_W-1:0] period;
   logic             valid;
   logic             match;
   logic             timeout;

   always #5 clock = ~clock;

   pwm_pulse_meter #(
      .CNT_W      (CNT_W),
      .EXP_LOW    (EXP_LOW),
      .EXP_PERIOD (EXP_PERIOD)
   ) dut (
      .clock     (clock),
      .reset     (reset),
      .en        (en),
      .f_in      (f_in),
      .low_width (low_width),
      .period    (period),
      .valid     (valid),
      .match     (match),
      .timeout   (timeout)
   );

   int n_pass  = 0;
   int n_total = 0;
   int cyc     = 0;

   // Reference model: f_in samples seen at past edges plus timestamps of
   // the accepted fall and rise of the current period.
   bit               samp_q[$];
   bit               armed;
   bit               seen_rise;
   int               t_fall;
   int               t_rise;
   logic [CNT_W-1:0] m_low;
   logic [CNT_W-1:0] m_period;
   logic             m_match;
   logic             m_valid;
   logic             m_timeout;
   meter_state_t     m_state;

   // Observed-event bookkeeping for directed checks.
   int valid_seen;
   int timeout_seen;
   int first_valid_cyc;
   int last_timeout_cyc;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_total++;
      assert (obs === expv) n_pass++;
      else $error("FAIL %s: observed %0d expected %0d at cycle %0d", tag, obs, expv, cyc);
   endtask

   task automatic model_edge(input bit cur_f, input bit cur_en, input bit cur_rst);
      bit fall;
      bit rise;
      if (!cur_rst) begin
         samp_q    = '{1'b1, 1'b1, 1'b1};
         armed     = 1'b0;
         seen_rise = 1'b0;
         m_low     = '0;
         m_period  = '0;
         m_match   = 1'b0;
         m_valid   = 1'b0;
         m_timeout = 1'b0;
      end else begin
         // An f_in change becomes a detected edge two edges after it is sampled.
         fall      = samp_q[2] && !samp_q[1];
         rise      = !samp_q[2] && samp_q[1];
         m_valid   = 1'b0;
         m_timeout = 1'b0;
         if (!cur_en) begin
            armed = 1'b0;
         end else if (armed && (cyc - t_fall) == MAXC) begin
            m_timeout = 1'b1;
            armed     = 1'b0;
         end else if (fall && (!armed || seen_rise)) begin
            if (armed) begin
               m_valid  = 1'b1;
               m_period = CNT_W'(cyc - t_fall);
               m_low    = CNT_W'(t_rise - t_fall);
               m_match  = (t_rise - t_fall == EXP_LOW) && (cyc - t_fall == EXP_PERIOD);
            end
            armed     = 1'b1;
            t_fall    = cyc;
            seen_rise = 1'b0;
         end else if (rise && armed && !seen_rise) begin
            t_rise    = cyc;
            seen_rise = 1'b1;
         end
         void'(samp_q.pop_back());
         samp_q.push_front(cur_f);
      end
      m_state = !armed ? IDLE : (seen_rise ? HIGH : LOW);
   endtask

   // One clock: apply the inputs present at the edge to the model, then
   // compare every output shortly after the edge.
   task automatic step();
      bit cur_f;
      bit cur_en;
      bit cur_rst;
      cur_f   = f_in;
      cur_en  = en;
      cur_rst = reset;
      @(posedge clock);
      cyc++;
      model_edge(cur_f, cur_en, cur_rst);
      #1;
      check("valid",     32'(valid),       32'(m_valid));
      check("timeout",   32'(timeout),     32'(m_timeout));
      check("low_width", 32'(low_width),   32'(m_low));
      check("period",    32'(period),      32'(m_period));
      check("match",     32'(match),       32'(m_match));
      check("state",     32'(dut.r_state), 32'(m_state));
      if (valid === 1'b1) begin
         valid_seen++;
         if (first_valid_cyc < 0) first_valid_cyc = cyc;
      end
      if (timeout === 1'b1) begin
         timeout_seen++;
         last_timeout_cyc = cyc;
      end
   endtask

   task automatic drive(input bit lvl, input int n);
      for (int i = 0; i < n; i++) begin
         f_in = lvl;
         step();
      end
   endtask

   initial begin
      int raw_fall;
      int lo;
      int hi;
      samp_q = '{1'b1, 1'b1, 1'b1};
      armed = 1'b0;
      seen_rise = 1'b0;
      t_fall = 0;
      t_rise = 0;
      valid_seen = 0;
      timeout_seen = 0;
      first_valid_cyc = -1;
      last_timeout_cyc = -1;

      // Reset state.
      reset = 1'b0;
      en    = 1'b0;
      f_in  = 1'b1;
      repeat (3) step();
      check("rst_low_width", 32'(low_width), 32'd0);
      check("rst_period",    32'(period),    32'd0);
      reset = 1'b1;
      en    = 1'b1;

      // Generator waveform (low for counts 20..89 of 500), with a one-cycle
      // reset in the HIGH phase of the third period.
      raw_fall = -1;
      for (int p = 0; p < 5; p++) begin
         for (int c = 0; c < 500; c++) begin
            f_in  = (c >= 20 && c <= 89) ? 1'b0 : 1'b1;
            reset = (p == 2 && c == 200) ? 1'b0 : 1'b1;
            if (raw_fall < 0 && f_in == 1'b0) raw_fall = cyc + 1;
            step();
            if (p == 2 && c == 200) begin
               check("midrst_low_width", 32'(low_width), 32'd0);
               check("midrst_valid",     32'(valid),     32'd0);
            end
            if (p == 1 && c == 30) begin
               check("gen_low_width", 32'(low_width), 32'd70);
               check("gen_period",    32'(period),    32'd500);
               check("gen_match",     32'(match),     32'd1);
            end
         end
      end
      reset = 1'b1;
      check("first_valid_delay", 32'(first_valid_cyc - raw_fall), 32'd502);
      check("gen_valid_count",   32'(valid_seen), 32'd3);

      // Low 10 / high 30.
      for (int p = 0; p < 6; p++) begin
         drive(1'b0, 10);
         drive(1'b1, 30);
      end
      check("p40_low_width", 32'(low_width), 32'd10);
      check("p40_period",    32'(period),    32'd40);
      check("p40_match",     32'(match),     32'd0);

      // en dropped for 5 cycles inside a low pulse.
      for (int p = 0; p < 4; p++) begin
         for (int c = 0; c < 40; c++) begin
            f_in = (c < 10) ? 1'b0 : 1'b1;
            en   = (p == 1 && c >= 3 && c < 8) ? 1'b0 : 1'b1;
            step();
         end
      end
      en = 1'b1;

      // Minimum pulse: low 1 / high 1.
      for (int p = 0; p < 12; p++) begin
         drive(1'b0, 1);
         drive(1'b1, 1);
      end
      check("glitch_low_width", 32'(low_width), 32'd1);
      check("glitch_period",    32'(period),    32'd2);

      // Random periods, some exactly nominal, with occasional en drops.
      for (int p = 0; p < 40; p++) begin
         if ($urandom_range(0, 7) == 0) begin
            lo = 70;
            hi = 430;
         end else begin
            lo = $urandom_range(1, 20);
            hi = $urandom_range(1, 40);
         end
         for (int c = 0; c < lo + hi; c++) begin
            f_in = (c < lo) ? 1'b0 : 1'b1;
            en   = ($urandom_range(0, 63) == 0) ? 1'b0 : 1'b1;
            step();
         end
      end
      en = 1'b1;

      // Saturation: fresh reset, one fall, then f_in held low.
      reset = 1'b0;
      drive(1'b1, 1);
      reset = 1'b1;
      drive(1'b1, 5);
      valid_seen   = 0;
      timeout_seen = 0;
      raw_fall     = cyc + 1;
      drive(1'b0, 4200);
      check("sat_timeout_count", 32'(timeout_seen), 32'd1);
      check("sat_timeout_delay", 32'(last_timeout_cyc - (raw_fall + 2)), 32'(MAXC));
      check("sat_no_valid",      32'(valid_seen), 32'd0);
      check("sat_low_width",     32'(low_width), 32'd0);

      // Recovery after timeout.
      for (int p = 0; p < 3; p++) begin
         drive(1'b1, 30);
         drive(1'b0, 10);
      end
      drive(1'b1, 30);
      drive(1'b0, 5);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
